agtb2: RTL and testbench
========================

Name: agtb2

Overview:
Unsigned magnitude comparator for two WIDTH-bit operands.
- Primary output agtb is purely combinational: 1 when a > b.
- A registered result stage with valid tagging sits alongside it for downstream clocked logic.
- Used as a leaf compare element in datapath/control logic.

Parameters:
WIDTH, 2, operand width in bits (minimum 1).

Ports:
clk  input  1  system clock, rising-edge active
rst_n  input  1  asynchronous active-low reset
a  input  WIDTH  operand A, unsigned
b  input  WIDTH  operand B, unsigned
agtb  output  1  combinational a > b
in_valid  input  1  qualifies a/b for the registered stage
agtb_q  output  1  registered a > b
aeqb_q  output  1  registered a == b
altb_q  output  1  registered a < b
out_valid  output  1  registered in_valid

Interface (already decided):
- One clock, clk.
- Reset rst_n is asynchronous and active-low.

Behaviour:
- agtb = (a > b), unsigned, zero latency.
  - Independent of clk and rst_n; valid even with no clock running.
  - No X propagation for known inputs.
- Comparison is MSB-first:
  - The first differing bit from the MSB decides the result.
  - All bits equal gives agtb = 0.
- Registered stage, on rising clk edge with rst_n high:
  - out_valid <= in_valid.
  - When in_valid = 1: agtb_q/aeqb_q/altb_q <= compare(a, b).
  - When in_valid = 0: flags hold their previous values.
- Latency of the registered stage is 1 cycle from in_valid to out_valid.
- Flag encoding: exactly one of agtb_q, aeqb_q, altb_q is 1 after the first valid sample (one-hot).
- Reset (rst_n low, asynchronous, any time including mid-operation):
  - agtb_q = 0, altb_q = 0, out_valid = 0.
  - aeqb_q = 1 (reset state represents "equal").
  - One-hot encoding is therefore kept in reset too.
  - Release is synchronous to the next clk edge; the first capture occurs on the first edge with rst_n high.
- Boundaries:
  - a = b = all-ones gives agtb = 0.
  - a = all-ones, b = 0 gives agtb = 1.
  - a = 0, b = all-ones gives agtb = 0.
- No overflow: no arithmetic wider than WIDTH is required.

Optional Feature:
Macro AGTB2_STATS_EN.
- Defined:
  - Adds output gt_count, 16 bits.
  - gt_count increments on each clk edge where in_valid = 1 and a > b.
  - Saturates at 16'hFFFF.
  - Cleared to 0 by rst_n asynchronously.
- Undefined: the port and counter do not exist; all other behaviour is identical.

Decomposition:
- Package agtb2_pkg holds:
  - Default width constant AGTB2_WIDTH = 2.
  - Typedef cmp_res_t, a 3-bit one-hot {gt, eq, lt}.
  - Reset constant CMP_RES_RST = eq.
- One sub-module, agtb2_bit_cmp:
  - Single-bit compare cell producing gt/eq from ai, bi.
  - Chained MSB-to-LSB by generate to form the WIDTH-bit result.
  - The same chain drives agtb and the registered flags.

Test Plan:
- Combinational sweep, WIDTH=2, 200 ns per vector, no clock:
  - (a,b) = (00,00) -> agtb 0
  - (01,00) -> 1
  - (01,11) -> 0
  - (10,10) -> 0
  - (10,00) -> 1
  - (11,11) -> 0
  - (11,01) -> 1
- Exhaustive 16-combination check of agtb against a reference model a > b, WIDTH=2.
- Reset: assert rst_n=0 mid-stream -> immediately agtb_q=0, aeqb_q=1, altb_q=0, out_valid=0; combinational agtb still tracks inputs.
- Registered path:
  - in_valid=1, a=11, b=01 at edge N -> out_valid=1, agtb_q=1 after edge N.
  - in_valid=0 with a=00, b=11 at edge N+1 -> out_valid=0, flags held (agtb_q stays 1).
- One-hot check: random valid stimulus over 1000 cycles -> agtb_q+aeqb_q+altb_q == 1 every cycle.
- AGTB2_STATS_EN: 5 valid cycles with a>b interleaved with 3 cycles with a<=b -> gt_count=5; gt_count preloaded to 16'hFFFE and given 3 more a>b cycles -> holds 16'hFFFF.

Source files
------------

// File: rtl/agtb2_pkg.sv
// Shared types and constants for the agtb2 unsigned magnitude comparator.
package agtb2_pkg;

    localparam int AGTB2_WIDTH = 2;

    typedef struct packed {
        logic gt;
        logic eq;
        logic lt;
    } cmp_res_t;

    localparam cmp_res_t CMP_RES_RST = 3'b010;

endpackage

// File: rtl/agtb2_bit_cmp.sv
// One slice of the MSB-first compare chain: a decision made at a more
// significant bit is carried through unchanged.
module agtb2_bit_cmp (
    input  logic ai,
    input  logic bi,
    input  logic gt_in,
    input  logic eq_in,
    output logic gt_out,
    output logic eq_out
);

    assign gt_out = gt_in | (eq_in & ai & ~bi);
    assign eq_out = eq_in & ~(ai ^ bi);

endmodule

// File: rtl/agtb2.sv
// Unsigned WIDTH-bit comparator: combinational agtb plus a registered one-hot
// {gt,eq,lt} stage with valid tagging. AGTB2_STATS_EN adds a saturating gt_count.
module agtb2
    import agtb2_pkg::*;
#(
    parameter int WIDTH = AGTB2_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             in_valid,
    output logic             agtb,
    output logic             agtb_q,
    output logic             aeqb_q,
    output logic             altb_q,
`ifdef AGTB2_STATS_EN
    output logic [15:0]      gt_count,
`endif
    output logic             out_valid
);

    // Index WIDTH is the seed above the MSB: nothing decided yet, all equal.
    logic [WIDTH:0] w_gtChain;
    logic [WIDTH:0] w_eqChain;
    cmp_res_t       w_res;
    cmp_res_t       r_res;
    logic           r_valid;

    assign w_gtChain[WIDTH] = 1'b0;
    assign w_eqChain[WIDTH] = 1'b1;

    for (genvar i = WIDTH - 1; i >= 0; i--) begin : g_chain
        agtb2_bit_cmp u_cell (
            .ai     (a[i]),
            .bi     (b[i]),
            .gt_in  (w_gtChain[i+1]),
            .eq_in  (w_eqChain[i+1]),
            .gt_out (w_gtChain[i]),
            .eq_out (w_eqChain[i])
        );
    end

    assign w_res = '{gt: w_gtChain[0], eq: w_eqChain[0], lt: ~(w_gtChain[0] | w_eqChain[0])};
    assign agtb  = w_res.gt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_res   <= CMP_RES_RST;
            r_valid <= 1'b0;
        end else begin
            r_valid <= in_valid;
            if (in_valid) begin
                r_res <= w_res;
            end
        end
    end

    assign agtb_q    = r_res.gt;
    assign aeqb_q    = r_res.eq;
    assign altb_q    = r_res.lt;
    assign out_valid = r_valid;

`ifdef AGTB2_STATS_EN
    logic [15:0] r_gtCount;

    // Counter sticks at all-ones rather than wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gtCount <= 16'd0;
        end else if (in_valid && w_res.gt && (r_gtCount != 16'hFFFF)) begin
            r_gtCount <= r_gtCount + 16'd1;
        end
    end

    assign gt_count = r_gtCount;
`endif

endmodule

// File: tb/tb_agtb2.sv
// Directed self-checking bench for agtb2 (WIDTH=2), including the optional
// AGTB2_STATS_EN counter when that macro is defined.
module tb_agtb2;

    logic       clk = 1'b0;
    logic       clkRun = 1'b0;
    logic       rst_n;
    logic [1:0] a;
    logic [1:0] b;
    logic       in_valid;
    logic       agtb;
    logic       agtb_q;
    logic       aeqb_q;
    logic       altb_q;
    logic       out_valid;
`ifdef AGTB2_STATS_EN
    logic [15:0] gt_count;
`endif

    int checks   = 0;
    int failures = 0;

    agtb2 #(.WIDTH(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a),
        .b         (b),
        .in_valid  (in_valid),
        .agtb      (agtb),
        .agtb_q    (agtb_q),
        .aeqb_q    (aeqb_q),
        .altb_q    (altb_q),
`ifdef AGTB2_STATS_EN
        .gt_count  (gt_count),
`endif
        .out_valid (out_valid)
    );

    always #5 clk = clkRun ? ~clk : clk;

    task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive on the falling edge, sample 1 time unit after the next rising edge.
    task automatic applyStimulus(input logic [1:0] va, input logic [1:0] vb, input logic vv);
        @(negedge clk);
        a        = va;
        b        = vb;
        in_valid = vv;
        @(posedge clk);
        #1;
    endtask

    task automatic checkFlags(input string tag, input logic gt, input logic eq, input logic lt, input logic v);
        checkOutput({tag, ".agtb_q"}, {15'd0, agtb_q}, {15'd0, gt});
        checkOutput({tag, ".aeqb_q"}, {15'd0, aeqb_q}, {15'd0, eq});
        checkOutput({tag, ".altb_q"}, {15'd0, altb_q}, {15'd0, lt});
        checkOutput({tag, ".out_valid"}, {15'd0, out_valid}, {15'd0, v});
    endtask

    logic [1:0] sweepA [7] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b10, 2'b11, 2'b11};
    logic [1:0] sweepB [7] = '{2'b00, 2'b00, 2'b11, 2'b10, 2'b00, 2'b11, 2'b01};
    logic       sweepE [7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    initial begin
        logic expGt, expEq, expLt;
        int   oneHotSum;

        rst_n    = 1'b1;
        a        = 2'b00;
        b        = 2'b00;
        in_valid = 1'b0;
        #5;
        rst_n = 1'b0;
        #5;
        checkFlags("reset_init", 1'b0, 1'b1, 1'b0, 1'b0);

        // Combinational behaviour with no clock running.
        for (int i = 0; i < 7; i++) begin
            a = sweepA[i];
            b = sweepB[i];
            #200;
            checkOutput($sformatf("sweep_%0d", i), {15'd0, agtb}, {15'd0, sweepE[i]});
        end

        for (int ia = 0; ia < 4; ia++) begin
            for (int ib = 0; ib < 4; ib++) begin
                a = 2'(ia);
                b = 2'(ib);
                #10;
                checkOutput($sformatf("exh_%0d_%0d", ia, ib), {15'd0, agtb}, {15'd0, (ia > ib)});
            end
        end

        clkRun = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;

        applyStimulus(2'b11, 2'b01, 1'b1);
        checkFlags("reg_gt", 1'b1, 1'b0, 1'b0, 1'b1);
        applyStimulus(2'b00, 2'b11, 1'b0);
        checkFlags("reg_hold", 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(2'b10, 2'b10, 1'b1);
        checkFlags("reg_eq", 1'b0, 1'b1, 1'b0, 1'b1);
        applyStimulus(2'b01, 2'b10, 1'b1);
        checkFlags("reg_lt", 1'b0, 1'b0, 1'b1, 1'b1);
        applyStimulus(2'b11, 2'b00, 1'b1);
        checkFlags("reg_max_zero", 1'b1, 1'b0, 1'b0, 1'b1);

        // Asynchronous reset in the middle of a cycle.
        #2;
        rst_n = 1'b0;
        #1;
        checkFlags("reset_mid", 1'b0, 1'b1, 1'b0, 1'b0);
        a = 2'b10;
        b = 2'b01;
        #1;
        checkOutput("reset_comb_gt", {15'd0, agtb}, 16'd1);
        a = 2'b01;
        b = 2'b10;
        #1;
        checkOutput("reset_comb_lt", {15'd0, agtb}, 16'd0);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        checkFlags("reset_held", 1'b0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        rst_n    = 1'b1;
        a        = 2'b00;
        b        = 2'b11;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        checkFlags("reset_release", 1'b0, 1'b0, 1'b1, 1'b1);

        // Random traffic against a reference model of the flag register.
        expGt = 1'b0;
        expEq = 1'b0;
        expLt = 1'b1;
        for (int n = 0; n < 1000; n++) begin
            logic [1:0] ra, rb;
            logic       rv;
            ra = 2'($urandom_range(0, 3));
            rb = 2'($urandom_range(0, 3));
            rv = 1'($urandom_range(0, 1));
            applyStimulus(ra, rb, rv);
            if (rv) begin
                expGt = (ra > rb);
                expEq = (ra == rb);
                expLt = (ra < rb);
            end
            oneHotSum = int'(agtb_q) + int'(aeqb_q) + int'(altb_q);
            checkOutput("onehot", 16'(oneHotSum), 16'd1);
            checkFlags("rand", expGt, expEq, expLt, rv);
            checkOutput("rand_comb", {15'd0, agtb}, {15'd0, (ra > rb)});
        end

`ifdef AGTB2_STATS_EN
        @(negedge clk);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        #1;
        checkOutput("cnt_reset", gt_count, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;

        applyStimulus(2'b11, 2'b00, 1'b1);
        applyStimulus(2'b01, 2'b01, 1'b1);
        applyStimulus(2'b10, 2'b01, 1'b1);
        applyStimulus(2'b00, 2'b11, 1'b1);
        applyStimulus(2'b01, 2'b00, 1'b1);
        applyStimulus(2'b10, 2'b11, 1'b1);
        applyStimulus(2'b11, 2'b10, 1'b1);
        applyStimulus(2'b11, 2'b00, 1'b0);
        applyStimulus(2'b10, 2'b00, 1'b1);
        checkOutput("cnt_five", gt_count, 16'd5);

        @(negedge clk);
        a        = 2'b11;
        b        = 2'b00;
        in_valid = 1'b1;
        repeat (65529) @(posedge clk);
        #1;
        checkOutput("cnt_fffe", gt_count, 16'hFFFE);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("cnt_saturate", gt_count, 16'hFFFF);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
